// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding, default width,
// and the half/full adder cell functions used by the ripple adder.
package mult_ctrl_pkg;

   localparam int MULT_N = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Both cells return {carry, sum}.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/nbit_adder_co.sv
// Combinational N-bit ripple adder with carry-out, half adder on bit 0, full adders above.
// Latency: zero cycles; backpressure: none (pure logic).
module nbit_adder_co
   import mult_ctrl_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:1] carry;

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_bit
         if (i == 0) begin : g_ha
            assign {carry[1], sum[0]} = half_add(a[0], b[0]);
         end else begin : g_fa
            assign {carry[i+1], sum[i]} = full_add(a[i], b[i], carry[i]);
         end
      end
   endgenerate

   assign cout = carry[N];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier sharing one N-bit adder over N ADD/SHIFT pairs.
// Latency: done 2N+1 cycles after accept; backpressure: start is ignored while busy, no queueing.
module shift_add_mult_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N + 1);

   state_t        state;
   logic [N-1:0]  a_reg;
   logic [N-1:0]  p_hi;
   logic [N-1:0]  q_reg;
   logic          c_reg;
   logic [CW-1:0] count;

   logic [N-1:0]  add_sum;
   logic          add_cout;

   nbit_adder_co #(.N(N)) u_adder (
      .a    (p_hi),
      .b    (a_reg),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_reg   <= '0;
         p_hi    <= '0;
         q_reg   <= '0;
         c_reg   <= 1'b0;
         count   <= '0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_reg <= multiplicand;
                  q_reg <= multiplier;
                  p_hi  <= '0;
                  c_reg <= 1'b0;
                  count <= CW'(N);
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               if (q_reg[0]) begin
                  {c_reg, p_hi} <= {add_cout, add_sum};
               end else begin
                  c_reg <= 1'b0;
               end
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               {c_reg, p_hi, q_reg} <= {1'b0, c_reg, p_hi, q_reg[N-1:1]};
               count <= count - 1'b1;
               // Product is captured from the final shift so it is visible during DONE.
               if (count == CW'(1)) begin
                  product <= {c_reg, p_hi, q_reg[N-1:1]};
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  state <= S_ADD;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: scenario tasks plus a product scoreboard.
module tb_shift_add_mult_ctrl;
   import mult_ctrl_pkg::*;

   localparam int N = MULT_N;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int errors = 0;
   int checks = 0;
   logic [2*N-1:0] exp_q[$];

   always #5 clk = ~clk;

   shift_add_mult_ctrl #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   // Every done pulse must match the oldest outstanding expected product.
   task automatic monitor();
      logic [2*N-1:0] e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: done=1 product=%0d, required no pulse", product);
            end else begin
               e = exp_q.pop_front();
               if (product !== e) begin
                  errors++;
                  $display("FAIL product: got %0d, required %0d", product, e);
               end
            end
         end
      end
   endtask

   task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
      logic [2*N-1:0] wa;
      logic [2*N-1:0] wb;
      wa = {{N{1'b0}}, a};
      wb = {{N{1'b0}}, b};
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      if (push) exp_q.push_back(wa * wb);
      @(posedge clk);
      #1;
      start        = 1'b0;
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
   endtask

   // Edges after the accept edge until done is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
      checks++; if (product !== '0) begin errors++; $display("FAIL reset_product: got %0d, required 0", product); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int lat;
      accept(8'd13, 8'd11, 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b, required 1", busy); end
      wait_done(lat);
      checks++; if (lat !== 2*N) begin errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, 2*N); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_in_done: got %b, required 1", busy); end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b, required 0", busy); end
      checks++; if (product !== 16'd143) begin errors++; $display("FAIL basic_product_hold: got %0d, required 143", product); end
   endtask

   task automatic test_max();
      int lat;
      accept(8'd255, 8'd255, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 2*N) begin errors++; $display("FAIL max_latency: got %0d, required %0d", lat, 2*N); end
      @(posedge clk);
      #1;
      checks++; if (product !== 16'hFE01) begin errors++; $display("FAIL max_product_hold: got %0h, required fe01", product); end
   endtask

   task automatic test_zero();
      int lat;
      accept(8'd0, 8'd200, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 2*N) begin errors++; $display("FAIL zero_a_latency: got %0d, required %0d", lat, 2*N); end
      @(posedge clk);
      #1;
      accept(8'd200, 8'd0, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 2*N) begin errors++; $display("FAIL zero_b_latency: got %0d, required %0d", lat, 2*N); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_ignore_start();
      int lat;
      int busy_cycles;
      accept(8'd3, 8'd5, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      multiplicand = 8'd7;
      multiplier   = 8'd7;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      checks++; if (lat !== 2*N - 4) begin errors++; $display("FAIL ignore_latency: got %0d, required %0d", lat, 2*N - 4); end
      multiplicand = 8'd7;
      multiplier   = 8'd7;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_done_start: busy=%b, required 0", busy); end
      busy_cycles = 0;
      repeat (2*N + 4) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1) busy_cycles++;
      end
      checks++; if (busy_cycles !== 0) begin errors++; $display("FAIL ignore_no_restart: busy cycles %0d, required 0", busy_cycles); end
   endtask

   task automatic test_reset_abort();
      int lat;
      accept(8'd100, 8'd100, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b, required 0", done); end
      checks++; if (product !== '0) begin errors++; $display("FAIL abort_product: got %0d, required 0", product); end
      repeat (2*N + 4) @(posedge clk);
      #1;
      accept(8'd2, 8'd3, 1'b1);
      wait_done(lat);
      checks++; if (lat !== 2*N) begin errors++; $display("FAIL abort_retry_latency: got %0d, required %0d", lat, 2*N); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int lat1;
      int lat2;
      multiplicand = 8'd9;
      multiplier   = 8'd9;
      start        = 1'b1;
      exp_q.push_back(16'd81);
      @(posedge clk);
      #1;
      wait_done(lat1);
      checks++; if (lat1 !== 2*N) begin errors++; $display("FAIL b2b_first_latency: got %0d, required %0d", lat1, 2*N); end
      multiplicand = 8'd12;
      multiplier   = 8'd10;
      exp_q.push_back(16'd120);
      wait_done(lat2);
      start = 1'b0;
      checks++; if (lat2 !== 2*N + 2) begin errors++; $display("FAIL b2b_interval: got %0d, required %0d", lat2, 2*N + 2); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_max();
      test_zero();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL outstanding: %0d results never produced, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Sequential unsigned shift-and-add multiplier controller. It schedules one shared N-bit ripple adder over N iterations to form a 2N-bit product. It sits beside the combinational adder datapath in the COA arithmetic set and uses a start/busy/done handshake toward the requester.

Parameters:
N, 8, operand width in bits; product width is 2N; N >= 2.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset; one clock, synchronous, active-low.
start  input  1  request; sampled only in IDLE.
multiplicand  input  N  operand A; latched when start is accepted.
multiplier  input  N  operand B; latched when start is accepted.
busy  output  1  high from the cycle after accept through the DONE cycle.
done  output  1  one-cycle pulse; product is valid in this cycle.
product  output  2N  result {P_hi, Q}; held stable until the next accept.

Behaviour:
- Reset: rst_n low at a clock edge sets state=IDLE, busy=0, done=0, product=0, and clears all internal registers (A, P_hi, Q, C, count). A reset in any state, including mid-operation, aborts the operation with no done pulse.
- Registers:
  - A[N-1:0]: multiplicand.
  - P_hi[N-1:0]: partial product, upper half.
  - Q[N-1:0]: multiplier; becomes the lower product half as it shifts.
  - C: adder carry.
  - count: $clog2(N+1) bits.
- FSM states: IDLE, ADD, SHIFT, DONE. Encodings come from the shared package.
- IDLE:
  - if start=1, latch A=multiplicand, Q=multiplier, P_hi=0, C=0, count=N, then go to ADD.
  - otherwise stay in IDLE.
- ADD:
  - if Q[0]=1, {C, P_hi} <= P_hi + A, computed by the adder sub-module with a full N+1-bit result.
  - if Q[0]=0, P_hi is held and C <= 0.
  - next state is SHIFT.
- SHIFT:
  - {C, P_hi, Q} <= {1'b0, C, P_hi, Q} >> 1, a logical right shift of the (2N+1)-bit vector.
  - count <= count-1.
  - if count-1 == 0, go to DONE; otherwise go to ADD.
- DONE:
  - done=1 for exactly this cycle.
  - product register <= {P_hi, Q}, visible in this same cycle; implement it as a combinational pass or load it on the last SHIFT.
  - next state is IDLE unconditionally.
- Latency: with start accepted at edge t, ADD/SHIFT pairs occupy t+1 .. t+2N, and done is high in cycle t+2N+1. For N=8, done comes 17 cycles after accept.
- busy equals (state != IDLE).
- done and busy are both high in the DONE cycle.
- start while busy=1, including the DONE cycle, is ignored. There is no queueing.
- Back-to-back: start high in the first IDLE cycle after DONE is accepted. Minimum issue interval is 2N+2 cycles.
- Arithmetic: unsigned only; no overflow is possible. Maximum result is (2^N-1)^2 < 2^2N.
- Multiplier = 0 or multiplicand = 0 still takes the full 2N+1 cycles and gives product=0.
- Operand inputs may change freely after the accept cycle.
- product keeps its last value through IDLE. It is cleared only by reset.

Decomposition:
- Shared package mult_ctrl_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_ADD=2'd1, S_SHIFT=2'd2, S_DONE=2'd3;
  - the default width constant MULT_N=8.
- One sub-module, nbit_adder_co (parameter N, ports a, b, sum[N-1:0], cout). It is a combinational ripple adder with explicit carry-out, built from half/full adder cells.
- The FSM, shift register and counter live in shift_add_mult_ctrl.

Test Plan:
- Reset, then start with A=13, B=11 (N=8) -> busy rises next cycle; done pulses exactly 17 cycles after the accept edge; product=143 (0x008F).
- A=255, B=255 -> product=65025 (0xFE01); carry-propagation path exercised on every ADD.
- A=0, B=200, then A=200, B=0 -> product=0 both times; each run still takes 17 cycles.
- Accept A=3, B=5; pulse start with A=7, B=7 at cycle 5 and again in the DONE cycle -> product=15, done pulses once, no second operation starts.
- Accept A=100, B=100; drop rst_n for one cycle at cycle 8 -> next cycle state=IDLE, busy=0, product=0, no done pulse; a following start with A=2, B=3 gives product=6.
- Back-to-back: start held high continuously with A=9, B=9, then A=12, B=10 applied right after done -> done pulses 18 cycles apart; products are 81, then 120.
